// File: rtl/multiword_add_pkg.sv
// Shared types and defaults for the multi-word sequential adder.
// The optional subtract mode is enabled by defining MULTIWORD_ADD_SUB_EN.
package multiword_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_WORDS = 4;

  // Slice index width; a single-word build still needs a 1-bit index.
  function automatic int idx_width(input int words);
    if (words > 1) begin
      return $clog2(words);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/multiword_add_ctrl_fulladder4.sv
// Combinational ripple-carry adder slice shared by the multi-word sequencer.
module fullAdder4 #(
  parameter int width = 4
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic             Cin,
  output logic [width-1:0] sum,
  output logic             Cout
);

  logic [width:0] carry;

  assign carry[0] = Cin;

  for (genvar i = 0; i < width; i++) begin : g_bit
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign Cout = carry[width];

endmodule

// File: rtl/multiword_add_ctrl.sv
// Adds two WORDS*WIDTH-bit operands over WORDS cycles through one WIDTH-bit adder.
// Defining MULTIWORD_ADD_SUB_EN adds a 'sub' port selecting a - b.
module multiword_add_ctrl
  import multiword_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int WORDS = DEF_WORDS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [WORDS*WIDTH-1:0] a,
  input  logic [WORDS*WIDTH-1:0] b,
  input  logic                   Cin,
`ifdef MULTIWORD_ADD_SUB_EN
  input  logic                   sub,
`endif
  output logic                   busy,
  output logic                   done,
  output logic [WORDS*WIDTH-1:0] sum,
  output logic                   Cout
);

  localparam int N  = WORDS * WIDTH;
  localparam int IW = idx_width(WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  state_t          state;
  state_t          next_state;
  logic [IW-1:0]   idx;
  logic            carry_q;
  logic [N-1:0]    a_q;
  logic [N-1:0]    b_q;
  logic [WIDTH-1:0] a_slice;
  logic [WIDTH-1:0] b_slice;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             first_carry;
`ifdef MULTIWORD_ADD_SUB_EN
  logic             sub_q;
`endif

  // Slice select; subtraction feeds the inverted B slice (two's complement with carry-in 1).
  always_comb begin
    a_slice = a_q[idx*WIDTH +: WIDTH];
    b_slice = b_q[idx*WIDTH +: WIDTH];
`ifdef MULTIWORD_ADD_SUB_EN
    if (sub_q) begin
      b_slice = ~b_q[idx*WIDTH +: WIDTH];
    end else begin
      b_slice = b_q[idx*WIDTH +: WIDTH];
    end
    if (sub) begin
      first_carry = 1'b1;
    end else begin
      first_carry = Cin;
    end
`else
    first_carry = Cin;
`endif
  end

  fullAdder4 #(.width(WIDTH)) u_adder (
    .a    (a_slice),
    .b    (b_slice),
    .Cin  (carry_q),
    .sum  (add_sum),
    .Cout (add_cout)
  );

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = RUN;
        end else begin
          next_state = IDLE;
        end
      end
      RUN: begin
        if (idx == LAST_IDX) begin
          next_state = DONE;
        end else begin
          next_state = RUN;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State, operand/result registers; busy/done registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum     <= '0;
      Cout    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef MULTIWORD_ADD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state <= next_state;
      busy  <= (next_state == RUN);
      done  <= (next_state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= first_carry;
            idx     <= '0;
            sum     <= '0;
`ifdef MULTIWORD_ADD_SUB_EN
            sub_q   <= sub;
`endif
          end
        end
        RUN: begin
          sum[idx*WIDTH +: WIDTH] <= add_sum;
          carry_q                 <= add_cout;
          idx                     <= idx + IW'(1);
          if (idx == LAST_IDX) begin
            Cout <= add_cout;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiword_add_ctrl.sv
// Scoreboard bench for multiword_add_ctrl: an 8-bit (4x2) and a 16-bit (4x4) instance.
module tb_multiword_add_ctrl;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  logic       start2 = 1'b0, cin2 = 1'b0;
  logic [7:0] a2 = 8'h00, b2 = 8'h00;
  logic       busy2, done2, cout2;
  logic [7:0] sum2;
`ifdef MULTIWORD_ADD_SUB_EN
  logic       sub2 = 1'b0;
  logic       sub4 = 1'b0;
`endif

  logic        start4 = 1'b0, cin4 = 1'b0;
  logic [15:0] a4 = 16'h0000, b4 = 16'h0000;
  logic        busy4, done4, cout4;
  logic [15:0] sum4;

  exp_t q2[$];
  exp_t q4[$];
  logic last_cout2 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multiword_add_ctrl #(.WIDTH(4), .WORDS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .Cin(cin2),
`ifdef MULTIWORD_ADD_SUB_EN
    .sub(sub2),
`endif
    .busy(busy2), .done(done2), .sum(sum2), .Cout(cout2)
  );

  multiword_add_ctrl #(.WIDTH(4), .WORDS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .Cin(cin4),
`ifdef MULTIWORD_ADD_SUB_EN
    .sub(sub4),
`endif
    .busy(busy4), .done(done4), .sum(sum4), .Cout(cout4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: pop one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done2) begin
      if (q2.size() == 0) begin
        check("done2_unexpected", 32'd1, 32'd0);
      end else begin
        e = q2.pop_front();
        check("sum2", {24'd0, sum2}, {16'd0, e.sum});
        check("cout2", {31'd0, cout2}, {31'd0, e.cout});
        check("done2_cycle", cyc, e.cyc);
      end
    end
    if (!rst && done4) begin
      if (q4.size() == 0) begin
        check("done4_unexpected", 32'd1, 32'd0);
      end else begin
        e = q4.pop_front();
        check("sum4", {16'd0, sum4}, {16'd0, e.sum});
        check("cout4", {31'd0, cout4}, {31'd0, e.cout});
        check("done4_cycle", cyc, e.cyc);
      end
    end
  end

  // One 8-bit operation with busy/hold checks along the way.
  task automatic op2(input logic [7:0] a, input logic [7:0] b, input logic cin,
                     input logic [7:0] exp_sum, input logic exp_cout);
    int k;
    @(negedge clk);
    a2 = a; b2 = b; cin2 = cin; start2 = 1'b1;
    k = cyc + 1;
    q2.push_back('{{8'd0, exp_sum}, exp_cout, k + 2});
    @(negedge clk);
    start2 = 1'b0; a2 = 8'h5A; b2 = 8'hA5;
    check("accept_sum_clear", {24'd0, sum2}, 32'd0);
    check("accept_cout_hold", {31'd0, cout2}, {31'd0, last_cout2});
    check("busy_run0", {31'd0, busy2}, 32'd1);
    @(negedge clk);
    check("busy_run1", {31'd0, busy2}, 32'd1);
    @(negedge clk);
    check("busy_done", {31'd0, busy2}, 32'd0);
    @(negedge clk);
    check("idle_done_low", {31'd0, done2}, 32'd0);
    check("idle_sum_hold", {24'd0, sum2}, {24'd0, exp_sum});
    last_cout2 = exp_cout;
  endtask

  initial begin
    int k;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy2}, 32'd0);
    check("rst_done", {31'd0, done2}, 32'd0);
    check("rst_sum", {24'd0, sum2}, 32'd0);
    check("rst_cout", {31'd0, cout2}, 32'd0);
    rst = 1'b0;

    op2(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
    op2(8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1);
    op2(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
    op2(8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0);

    // start held high; operands churn during RUN/DONE, reload just before re-accept.
    @(negedge clk);
    a2 = 8'h12; b2 = 8'h34; cin2 = 1'b0; start2 = 1'b1;
    k = cyc + 1;
    q2.push_back('{16'h0046, 1'b0, k + 2});
    q2.push_back('{16'h0003, 1'b0, k + 6});
    @(negedge clk); a2 = 8'hAA; b2 = 8'hAA;
    @(negedge clk); a2 = 8'hCC; b2 = 8'hCC;
    @(negedge clk); a2 = 8'hEE; b2 = 8'hEE;
    @(negedge clk); a2 = 8'h01; b2 = 8'h02;
    check("held_not_busy", {31'd0, busy2}, 32'd0);
    @(negedge clk);
    start2 = 1'b0;
    check("held_reaccept", {31'd0, busy2}, 32'd1);
    repeat (4) @(negedge clk);
    last_cout2 = 1'b0;

    op2(8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1);

    // Reset one cycle mid-RUN: aborts, outputs clear immediately.
    @(negedge clk);
    a2 = 8'h33; b2 = 8'h44; cin2 = 1'b0; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy2}, 32'd0);
    check("abort_done", {31'd0, done2}, 32'd0);
    check("abort_sum", {24'd0, sum2}, 32'd0);
    check("abort_cout", {31'd0, cout2}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_cout2 = 1'b0;
    repeat (4) @(negedge clk);
    op2(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);

    // 16-bit instance.
    @(negedge clk);
    a4 = 16'h1234; b4 = 16'hEDCC; cin4 = 1'b0; start4 = 1'b1;
    k = cyc + 1;
    q4.push_back('{16'h0000, 1'b1, k + 4});
    @(negedge clk);
    start4 = 1'b0;
    repeat (6) @(negedge clk);
    a4 = 16'h8000; b4 = 16'h8000; cin4 = 1'b1; start4 = 1'b1;
    k = cyc + 1;
    q4.push_back('{16'h0001, 1'b1, k + 4});
    @(negedge clk);
    start4 = 1'b0;
    repeat (6) @(negedge clk);

`ifdef MULTIWORD_ADD_SUB_EN
    sub2 = 1'b1;
    op2(8'h05, 8'h07, 1'b0, 8'hFE, 1'b0);
    op2(8'h07, 8'h05, 1'b0, 8'h02, 1'b1);
    sub2 = 1'b0;
`endif

    repeat (3) @(negedge clk);
    check("q2_drained", q2.size(), 32'd0);
    check("q4_drained", q4.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
